hazard_ctrl_mc: RTL

- Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Adds support for a multi-cycle execute operation (iterative mul/div) that holds the E stage for MC_LAT cycles.
- Generates forwarding selects, load-use stalls, branch flushes, an E-stage hold, and a bubble into the E/M register.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the datapath; consumes its register addresses and control, and drives StallF/StallD/FlushD/FlushE plus the new StallE/FlushM.

---
 rtl/hazard_ctrl_mc.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline, extended with an
// E-stage hold for iterative multi-cycle ops and a saturating stall counter.

module hazard_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        fwd
);
    // The younger producer in M must win over the older one in W.
    always_comb begin
        fwd = 2'b00;
        if (regWriteM && rdM != '0 && rdM == rsE)
            fwd = 2'b10;
        else if (regWriteW && rdW != '0 && rdW == rsE)
            fwd = 2'b01;
    end
endmodule

module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              McStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McBusy,
    output logic              McDoneE,
    output logic [PERF_W-1:0] StallCycles
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

    typedef enum logic {IDLE, BUSY} mcState_t;

    mcState_t            state, stateNext;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic                mcStall, lwStall;
    logic [1:0][REG_AW-1:0] rsE;
    logic [1:0][1:0]     fwdSel;

    assign rsE = {Rs2E, Rs1E};

    for (genvar i = 0; i < 2; i++) begin : gOpnd
        hazard_fwd_sel #(.REG_AW(REG_AW)) uFwd (
            .rsE      (rsE[i]),
            .rdM      (RdM),
            .rdW      (RdW),
            .regWriteM(RegWriteM),
            .regWriteW(RegWriteW),
            .fwd      (fwdSel[i])
        );
    end

    assign ForwardAE = fwdSel[0];
    assign ForwardBE = fwdSel[1];

    assign lwStall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The IDLE detection cycle is itself the first E cycle, so the counter
    // starts at MC_LAT-2 and the op releases E after MC_LAT cycles in total.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mcStall   = 1'b0;
        McDoneE   = 1'b0;
        case (state)
            IDLE: begin
                if (McStartE) begin
                    mcStall   = 1'b1;
                    stateNext = BUSY;
                    cntNext   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mcStall = 1'b1;
                    cntNext = cnt - 1'b1;
                end else begin
                    McDoneE   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign McBusy = (state == BUSY) || (state == IDLE && McStartE);
    assign StallF = lwStall | mcStall;
    assign StallD = lwStall | mcStall;
    assign StallE = mcStall;
    assign FlushM = mcStall;
    // While E holds, the branch/load in E has not resolved; do not flush.
    assign FlushD = PCSrcE & ~mcStall;
    assign FlushE = (lwStall | PCSrcE) & ~mcStall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCycles <= '0;
        else if (StallF && StallCycles != '1)
            StallCycles <= StallCycles + 1'b1;
    end
endmodule
